nibble_serial_add_seq: RTL

- Sequencer that performs a WIDTH-bit add or subtract on one shared external 4-bit adder slice (74AC283_1x1ADD4), one nibble per clock, LSB nibble first.
- Holds the carry between slices in a flip-flop.
- Used where area matters more than latency: one adder package plus registers replaces WIDTH/4 cascaded adders.
- Start/busy/done handshake to the requesting logic.

---
 rtl/nibble_serial_add_seq.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/nibble_serial_add_seq.sv
`default_nettype none
// ============================================================================
// Module      : nibble_serial_add_seq
// Description : Performs a WIDTH-bit add or subtract one nibble per clock on
//               a single external 4-bit adder slice, LSB nibble first. The
//               carry between slices is held in a flip-flop.
//               Handshake: START is accepted in IDLE or DONE. BUSY is high
//               while nibbles are being processed. DONE pulses for one cycle.
// Ports       : CLK, RST (async, active-high)
//               START, SUB, A, B, CI   - request and operands, sampled on the
//                                        accepting edge only
//               BUSY, DONE, Y, CO      - status and registered result
//               ADD_A, ADD_B, ADD_CI   - drive the shared adder slice
//               ADD_S, ADD_CO          - returned from the shared adder slice
// Revision    : 1.0 - initial release
// ============================================================================
module nibble_serial_add_seq #(
    parameter int WIDTH = 16
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             START,
    input  logic             SUB,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             CI,
    output logic             BUSY,
    output logic             DONE,
    output logic [WIDTH-1:0] Y,
    output logic             CO,
    output logic [3:0]       ADD_A,
    output logic [3:0]       ADD_B,
    output logic             ADD_CI,
    input  logic [3:0]       ADD_S,
    input  logic             ADD_CO
);

    localparam int N     = WIDTH / 4;
    localparam int CNT_W = $clog2(N);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             state_q,  state_d;
    logic [WIDTH-1:0]   a_sh_q,   a_sh_d;
    logic [WIDTH-1:0]   b_sh_q,   b_sh_d;
    logic [WIDTH-1:0]   res_sh_q, res_sh_d;
    logic               carry_q,  carry_d;
    logic [CNT_W-1:0]   count_q,  count_d;
    logic [WIDTH-1:0]   y_q,      y_d;
    logic               co_q,     co_d;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q  <= S_IDLE;
            a_sh_q   <= '0;
            b_sh_q   <= '0;
            res_sh_q <= '0;
            carry_q  <= 1'b0;
            count_q  <= '0;
            y_q      <= '0;
            co_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_sh_q   <= a_sh_d;
            b_sh_q   <= b_sh_d;
            res_sh_q <= res_sh_d;
            carry_q  <= carry_d;
            count_q  <= count_d;
            y_q      <= y_d;
            co_q     <= co_d;
        end
    end

    // The incoming sum nibble lands in the top of the result register so that
    // after N shifts the first (LSB) nibble has reached bit 0.
    logic [WIDTH-1:0] res_next;
    assign res_next = {ADD_S, res_sh_q[WIDTH-1:4]};

    always_comb begin
        state_d  = state_q;
        a_sh_d   = a_sh_q;
        b_sh_d   = b_sh_q;
        res_sh_d = res_sh_q;
        carry_d  = carry_q;
        count_d  = count_q;
        y_d      = y_q;
        co_d     = co_q;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (START) begin
                    // Subtraction is A + ~B + 1; CI plays no part then.
                    a_sh_d  = A;
                    b_sh_d  = SUB ? ~B : B;
                    carry_d = SUB ? 1'b1 : CI;
                    count_d = '0;
                    state_d = S_RUN;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_RUN: begin
                a_sh_d   = {4'b0000, a_sh_q[WIDTH-1:4]};
                b_sh_d   = {4'b0000, b_sh_q[WIDTH-1:4]};
                res_sh_d = res_next;
                carry_d  = ADD_CO;
                count_d  = count_q + CNT_W'(1);
                if (count_q == LAST_CNT) begin
                    y_d     = res_next;
                    co_d    = ADD_CO;
                    state_d = S_DONE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // The shared adder sees zeros whenever no operation is in flight.
    always_comb begin
        ADD_A  = 4'h0;
        ADD_B  = 4'h0;
        ADD_CI = 1'b0;
        if (state_q == S_RUN) begin
            ADD_A  = a_sh_q[3:0];
            ADD_B  = b_sh_q[3:0];
            ADD_CI = carry_q;
        end
    end

    assign BUSY = (state_q == S_RUN);
    assign DONE = (state_q == S_DONE);
    assign Y    = y_q;
    assign CO   = co_q;

endmodule
`default_nettype wire
